// File: rtl/clk_ratio_monitor_if.sv
// -----------------------------------------------------------------------------
// clk_ratio_monitor_if
//
// Bundles the observed divided clock, the monitor enable and all measurement
// results of clk_ratio_monitor. The reference clock and reset stay plain ports
// on the monitor itself.
//
//   i_mon_en    monitor enable (low = idle and clear)
//   i_div_clk   divided clock under observation, sampled as data
//   o_ratio     last measured period in reference cycles
//   o_high_cnt  reference cycles the clock was high within that period
//   o_valid     one-cycle pulse when o_ratio / o_high_cnt update
//   o_locked    ratio stable for LOCK_CNT consecutive measurements
//   o_timeout   no rising edge seen for 2^INT_WIDTH-1 reference cycles
//   o_duty_err  duty-cycle error flag
//
// Modports: slave = the monitor, master = whoever drives the stimulus and
// consumes the results.
// -----------------------------------------------------------------------------
interface clk_ratio_monitor_if #(
   parameter int INT_WIDTH = 8
);
   logic                 i_mon_en;
   logic                 i_div_clk;
   logic [INT_WIDTH-1:0] o_ratio;
   logic [INT_WIDTH-1:0] o_high_cnt;
   logic                 o_valid;
   logic                 o_locked;
   logic                 o_timeout;
   logic                 o_duty_err;

   modport master (
      output i_mon_en, i_div_clk,
      input  o_ratio, o_high_cnt, o_valid, o_locked, o_timeout, o_duty_err
   );

   modport slave (
      input  i_mon_en, i_div_clk,
      output o_ratio, o_high_cnt, o_valid, o_locked, o_timeout, o_duty_err
   );
endinterface

// File: rtl/clk_ratio_monitor.sv
// -----------------------------------------------------------------------------
// clk_ratio_monitor
//
// Samples a divided clock in the reference clock domain and recovers its
// division ratio (rise-to-rise period) and high-phase length. Reports lock
// once the ratio has been identical for LOCK_CNT captures and flags a stuck or
// absent divided clock with o_timeout.
//
// Ports:
//   i_ref_clk  reference clock, the only clock in the block
//   i_rst      asynchronous active-high reset
//   mon_if     clk_ratio_monitor_if.slave (enable, divided clock, results)
//
// Parameters:
//   INT_WIDTH    width of ratio and measurement counters
//   LOCK_CNT     identical captures needed for o_locked (2..15)
//   SYNC_STAGES  synchroniser depth on i_div_clk (>= 2)
//
// Build option:
//   CLK_MON_DUTY_CHECK_EN  when defined, o_duty_err flags captures where
//                          |2*high - period| > 1; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module clk_ratio_monitor #(
   parameter int INT_WIDTH   = 8,
   parameter int LOCK_CNT    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               i_ref_clk,
   input  logic               i_rst,
   clk_ratio_monitor_if.slave mon_if
);

   localparam logic [3:0] LP_LOCK_CNT = 4'(LOCK_CNT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_MEAS
   } state_t;

   // ---------------------------------------------------------------- front end
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic                   w_sync;
   logic                   w_rise;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_rise = w_sync & ~r_hist;

   // The synchroniser is not gated by i_mon_en so that a re-enable sees the
   // true current level and only a fresh edge can start a measurement.
   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge value of its neighbour; blocking here would
         // collapse the synchroniser chain into a single stage.
         r_sync <= {r_sync[SYNC_STAGES-2:0], mon_if.i_div_clk};
         r_hist <= w_sync;
      end
   end

   // ---------------------------------------------------------------- FSM
   state_t               r_state;
   state_t               w_state_nxt;
   logic [INT_WIDTH-1:0] r_per_cnt;
   logic [INT_WIDTH-1:0] r_hi_cnt;
   logic                 w_cnt_max;
   logic                 w_start;
   logic                 w_capture;
   logic                 w_tmo;
   logic                 w_clear;

   assign w_cnt_max = (r_per_cnt == '1);

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: a default assignment ahead of the case keeps every path driven,
      // so no latch is inferred for states or inputs not listed below.
      w_state_nxt = r_state;
      if (!mon_if.i_mon_en) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_ARM;
            S_ARM:   if (w_rise) w_state_nxt = S_MEAS;
            S_MEAS:  if (!w_rise && w_cnt_max) w_state_nxt = S_ARM;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // A rising edge always beats a counter reaching all-ones in the same cycle.
   always_comb begin
      w_start   = 1'b0;
      w_capture = 1'b0;
      w_tmo     = 1'b0;
      w_clear   = 1'b0;
      if (!mon_if.i_mon_en || r_state == S_IDLE) begin
         w_clear = 1'b1;
      end else begin
         w_start   = (r_state == S_ARM)  && w_rise;
         w_capture = (r_state == S_MEAS) && w_rise;
         w_tmo     = !w_rise && w_cnt_max;
      end
   end

   // ---------------------------------------------------------------- counters
   // In ARM r_per_cnt doubles as the wait-for-first-edge counter.
   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         r_per_cnt <= '0;
         r_hi_cnt  <= '0;
      end else if (w_clear || w_tmo) begin
         r_per_cnt <= '0;
         r_hi_cnt  <= '0;
      end else if (w_start || w_capture) begin
         // The edge cycle itself is the first cycle of the new period.
         r_per_cnt <= INT_WIDTH'(1);
         r_hi_cnt  <= INT_WIDTH'(1);
      end else if (r_state == S_MEAS) begin
         r_per_cnt <= r_per_cnt + 1'b1;
         if (w_sync) r_hi_cnt <= r_hi_cnt + 1'b1;
      end else if (r_state == S_ARM) begin
         r_per_cnt <= r_per_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- results
   logic [INT_WIDTH-1:0] r_ratio;
   logic [INT_WIDTH-1:0] r_high_cnt;
   logic                 r_valid;
   logic                 r_locked;
   logic                 r_timeout;
   logic [3:0]           r_match_cnt;
   logic [3:0]           w_match_nxt;

   // r_ratio still holds the previous capture; r_match_cnt==0 marks "no
   // previous capture since enable/timeout", so the first one always counts 1.
   always_comb begin
      w_match_nxt = 4'd1;
      if (r_match_cnt != 4'd0 && r_per_cnt == r_ratio) begin
         w_match_nxt = (r_match_cnt >= LP_LOCK_CNT) ? LP_LOCK_CNT
                                                    : r_match_cnt + 4'd1;
      end
   end

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ratio     <= '0;
         r_high_cnt  <= '0;
         r_valid     <= 1'b0;
         r_locked    <= 1'b0;
         r_timeout   <= 1'b0;
         r_match_cnt <= '0;
      end else begin
         r_valid <= w_capture;
         if (!mon_if.i_mon_en) begin
            // Ratio and high count deliberately hold across a disable.
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
            r_match_cnt <= '0;
         end else if (w_capture) begin
            r_ratio     <= r_per_cnt;
            r_high_cnt  <= r_hi_cnt;
            r_timeout   <= 1'b0;
            r_match_cnt <= w_match_nxt;
            r_locked    <= (w_match_nxt == LP_LOCK_CNT);
         end else if (w_tmo) begin
            r_timeout   <= 1'b1;
            r_locked    <= 1'b0;
            r_match_cnt <= '0;
         end
      end
   end

`ifdef CLK_MON_DUTY_CHECK_EN
   // ---------------------------------------------------------------- duty check
   // Signed difference 2*high - period; +/-1 is accepted so odd ratios pass.
   logic signed [INT_WIDTH+1:0] w_duty_diff;
   logic                        w_duty_bad;
   logic                        r_duty_err;

   assign w_duty_diff = $signed({1'b0, r_hi_cnt, 1'b0}) - $signed({2'b00, r_per_cnt});
   assign w_duty_bad  = (w_duty_diff > 1) || (w_duty_diff < -1);

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst)                  r_duty_err <= 1'b0;
      else if (!mon_if.i_mon_en)  r_duty_err <= 1'b0;
      else if (w_capture)         r_duty_err <= w_duty_bad;
   end

   assign mon_if.o_duty_err = r_duty_err;
`else
   assign mon_if.o_duty_err = 1'b0;
`endif

   assign mon_if.o_ratio    = r_ratio;
   assign mon_if.o_high_cnt = r_high_cnt;
   assign mon_if.o_valid    = r_valid;
   assign mon_if.o_locked   = r_locked;
   assign mon_if.o_timeout  = r_timeout;

endmodule
